// File: rtl/baud_tick_gen_prog_if.sv
// Increment programming bus for baud_tick_gen_prog.
//
// Signals:
//   inc_wr   - increment write strobe (master -> slave)
//   inc_data - new increment value, W bits (master -> slave)
//   inc_ack  - increment applied, one-cycle pulse (slave -> master)
//   inc_err  - zero write rejected, one-cycle pulse (slave -> master)
//   inc_cur  - increment currently used by the accumulator (slave -> master)
//
// W must match the ACC_WIDTH of the attached baud_tick_gen_prog.

interface baud_tick_gen_prog_if #(
    parameter int unsigned W = 16
);
    logic         inc_wr;
    logic [W-1:0] inc_data;
    logic         inc_ack;
    logic         inc_err;
    logic [W-1:0] inc_cur;

    modport master (
        output inc_wr,
        output inc_data,
        input  inc_ack,
        input  inc_err,
        input  inc_cur
    );

    modport slave (
        input  inc_wr,
        input  inc_data,
        output inc_ack,
        output inc_err,
        output inc_cur
    );
endinterface

// File: rtl/baud_tick_gen_prog.sv
// Programmable fractional baud tick generator.
//
// A W+1 bit phase accumulator adds the programmable increment every enabled cycle; each
// carry out of bit W-1 is one oversample tick. An oversample index counts ticks within a
// bit period and marks the mid-bit and end-of-bit ticks.
//
// Ports:
//   clk       - clock, all logic on the rising edge
//   rst       - synchronous active-high reset
//   enable    - run the accumulator; low holds accumulator and phase at 0
//   restart   - single-cycle phase realign (accumulator and phase to 0)
//   inc_bus   - increment programming bus (slave modport of baud_tick_gen_prog_if)
//   os_tick   - oversample tick
//   mid_tick  - tick at oversample index OVERSAMPLING/2-1
//   bit_tick  - tick at oversample index OVERSAMPLING-1
//   os_phase  - oversample index of the current tick
//
// Optional feature: define BAUD_TICK_SHADOW_INC_EN to make increment writes land in a
// shadow register that is only copied into use at a bit boundary (or while disabled).
// Without the macro, writes take effect at the write edge.

module baud_tick_gen_prog #(
    parameter int unsigned  CLK_FREQUENCY = 66000000,
    parameter int unsigned  BAUD          = 9600,
    parameter int unsigned  OVERSAMPLING  = 16,
    parameter int unsigned  ACC_WIDTH     = 16,
    localparam int unsigned PHASE_W       = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 restart,
    baud_tick_gen_prog_if.slave  inc_bus,
    output logic                 os_tick,
    output logic                 mid_tick,
    output logic                 bit_tick,
    output logic [PHASE_W-1:0]   os_phase
);

    // Reset increment: round-half-up(BAUD * OVERSAMPLING * 2^W / CLK_FREQUENCY), 64-bit math.
    localparam longint unsigned ACC_ONE        = 64'd1 << ACC_WIDTH;
    localparam longint unsigned INC_NUM        = 64'(BAUD) * 64'(OVERSAMPLING) * ACC_ONE;
    localparam longint unsigned CLK_64         = 64'(CLK_FREQUENCY);
    localparam longint unsigned INC_DEFAULT_64 = (CLK_64 == 64'd0) ? 64'd0 :
                                                 (64'd2 * INC_NUM + CLK_64) / (64'd2 * CLK_64);
    localparam logic [ACC_WIDTH-1:0] INC_DEFAULT = INC_DEFAULT_64[ACC_WIDTH-1:0];

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OVERSAMPLING - 1);
    localparam logic [PHASE_W-1:0] PHASE_MID  =
        PHASE_W'((OVERSAMPLING >= 2) ? (OVERSAMPLING / 2 - 1) : 0);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

    // Elaboration-time configuration checks.
    if (CLK_FREQUENCY == 0 || ACC_WIDTH == 0 || ACC_WIDTH > 32) begin : g_bad_cfg
        $error("baud_tick_gen_prog: CLK_FREQUENCY must be nonzero and ACC_WIDTH in 1..32");
    end
    if (INC_DEFAULT_64 == 64'd0) begin : g_bad_inc_zero
        $error("baud_tick_gen_prog: reset increment rounds to 0");
    end
    if (INC_DEFAULT_64 >= ACC_ONE) begin : g_bad_inc_big
        $error("baud_tick_gen_prog: reset increment does not fit in ACC_WIDTH bits");
    end
    if (!(OVERSAMPLING == 1 || (OVERSAMPLING >= 2 && (OVERSAMPLING % 2) == 0)))
    begin : g_bad_os
        $error("baud_tick_gen_prog: OVERSAMPLING must be 1 or an even number >= 2");
    end

    logic [ACC_WIDTH:0]   acc_q, acc_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [ACC_WIDTH-1:0] inc_cur_q, inc_cur_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 wr_ok, wr_zero;

    assign wr_ok   = inc_bus.inc_wr && (inc_bus.inc_data != '0);
    assign wr_zero = inc_bus.inc_wr && (inc_bus.inc_data == '0);

    // Carry bit of the registered accumulator is the tick; phase qualifies it. With
    // OVERSAMPLING=1 both compares are against 0, so all three ticks coincide.
    assign os_tick  = acc_q[ACC_WIDTH];
    assign bit_tick = os_tick && (phase_q == PHASE_LAST);
    assign mid_tick = os_tick && (phase_q == PHASE_MID);
    assign os_phase = phase_q;

    assign inc_bus.inc_cur = inc_cur_q;
    assign inc_bus.inc_ack = ack_q;
    assign inc_bus.inc_err = err_q;

    // Accumulator and oversample index. Restart and disable both win over a pending carry.
    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        if (!enable || restart) begin
            acc_d   = '0;
            phase_d = '0;
        end else begin
            acc_d = {1'b0, acc_q[ACC_WIDTH-1:0]} + {1'b0, inc_cur_q};
            if (os_tick) begin
                phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_ONE;
            end
        end
    end

    assign err_d = wr_zero;

`ifdef BAUD_TICK_SHADOW_INC_EN
    logic [ACC_WIDTH-1:0] shadow_q, shadow_d;
    logic                 pending_q, pending_d;

    // A write in the copy cycle is forwarded so the newest value is the one applied;
    // overwrites while pending collapse into a single ack.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        inc_cur_d = inc_cur_q;
        ack_d     = 1'b0;
        if (wr_ok) begin
            shadow_d  = inc_bus.inc_data;
            pending_d = 1'b1;
        end
        if (pending_d && (bit_tick || !enable)) begin
            inc_cur_d = shadow_d;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end
`else
    always_comb begin
        inc_cur_d = inc_cur_q;
        ack_d     = 1'b0;
        if (wr_ok) begin
            inc_cur_d = inc_bus.inc_data;
            ack_d     = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            phase_q   <= '0;
            inc_cur_q <= INC_DEFAULT;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            phase_q   <= phase_d;
            inc_cur_q <= inc_cur_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_baud_tick_gen_prog.sv
// Self-checking bench for baud_tick_gen_prog (W=16, OVERSAMPLING=16, 66 MHz, 9600 baud).
// The reference model tracks the total amount accumulated since the last realign; a tick
// is a crossing of a multiple of 2^16 and the oversample index is the tick count mod 16.

module tb_baud_tick_gen_prog;
    localparam int unsigned     OS        = 16;
    localparam longint unsigned M         = 65536;
    localparam int unsigned     INC_RESET = 153;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       restart;
    logic       os_tick;
    logic       mid_tick;
    logic       bit_tick;
    logic [3:0] os_phase;

    baud_tick_gen_prog_if #(.W(16)) bus ();

    baud_tick_gen_prog #(
        .CLK_FREQUENCY(66000000),
        .BAUD         (9600),
        .OVERSAMPLING (16),
        .ACC_WIDTH    (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .restart (restart),
        .inc_bus (bus),
        .os_tick (os_tick),
        .mid_tick(mid_tick),
        .bit_tick(bit_tick),
        .os_phase(os_phase)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    longint unsigned m_total  = 0;
    bit              m_tick   = 0;
    int unsigned     m_phase  = 0;
    int unsigned     m_inc    = INC_RESET;
    bit              m_ack    = 0;
    bit              m_err    = 0;
    bit              m_pend   = 0;
    int unsigned     m_shadow = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input bit rs, input bit wr,
                              input int unsigned d);
        bit              bit_now;
        longint unsigned old_total;
        longint unsigned ticks;
        bit_now = m_tick && (m_phase == OS - 1);
        if (r) begin
            m_total = 0; m_tick = 0; m_phase = 0; m_inc = INC_RESET;
            m_ack = 0; m_err = 0; m_pend = 0;
            return;
        end
        if (!en || rs) begin
            m_total = 0;
            m_tick  = 0;
        end else begin
            old_total = m_total;
            m_total   = m_total + longint'(m_inc);
            m_tick    = (m_total / M) != (old_total / M);
        end
        ticks   = m_total / M;
        m_phase = m_tick ? int'((ticks - 1) % OS) : int'(ticks % OS);
        m_err   = wr && (d == 0);
`ifdef BAUD_TICK_SHADOW_INC_EN
        m_ack = 0;
        if (wr && d != 0) begin
            m_shadow = d;
            m_pend   = 1;
        end
        if (m_pend && (bit_now || !en)) begin
            m_inc  = m_shadow;
            m_pend = 0;
            m_ack  = 1;
        end
`else
        m_ack = wr && (d != 0);
        if (m_ack) m_inc = d;
`endif
    endtask

    task automatic check_all();
        check_eq("os_tick",  os_tick,     m_tick);
        check_eq("mid_tick", mid_tick,    m_tick && (m_phase == OS / 2 - 1));
        check_eq("bit_tick", bit_tick,    m_tick && (m_phase == OS - 1));
        check_eq("os_phase", os_phase,    m_phase);
        check_eq("inc_cur",  bus.inc_cur, m_inc);
        check_eq("inc_ack",  bus.inc_ack, m_ack);
        check_eq("inc_err",  bus.inc_err, m_err);
    endtask

    task automatic step();
        bit          r, en, rs, wr;
        int unsigned d;
        r = rst; en = enable; rs = restart; wr = bus.inc_wr; d = bus.inc_data;
        @(posedge clk);
        model_edge(r, en, rs, wr, d);
        #1;
        check_all();
    endtask

    task automatic wr_inc(input logic [15:0] d);
        bus.inc_wr   = 1'b1;
        bus.inc_data = d;
        step();
        bus.inc_wr   = 1'b0;
    endtask

    // Steps until os_tick, returning the number of steps; 0 means the bound expired.
    task automatic steps_to_tick(input int bound, output int n);
        n = 0;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (os_tick) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int ticks, bits, mids, last_mid;
        int unsigned toggle_incs [3];
        toggle_incs = '{32'h4000, 32'h3000, 32'h0FFF};

        rst = 1'b1; enable = 1'b0; restart = 1'b0;
        bus.inc_wr = 1'b0; bus.inc_data = '0;
        #2;
        step(); step();
        check_eq("reset_inc_cur", bus.inc_cur, INC_RESET);
        check_eq("reset_ticks", {os_tick, mid_tick, bit_tick, bus.inc_ack, bus.inc_err}, 0);
        rst = 1'b0;

        enable = 1'b1;
        repeat (20) step();

        // Program 0x4000 while disabled so it applies at once in either build.
        enable = 1'b0;
        wr_inc(16'h4000);
        check_eq("wr_ack", bus.inc_ack, 1);
        check_eq("wr_cur", bus.inc_cur, 16'h4000);
        enable = 1'b1;
        restart = 1'b1; step(); restart = 1'b0;

        ticks = 0; bits = 0; mids = 0; last_mid = -100;
        for (int i = 1; i <= 128; i++) begin
            step();
            if (os_tick) ticks++;
            if (mid_tick) begin mids++; last_mid = i; end
            if (bit_tick) begin
                bits++;
                check_eq("mid_to_bit_gap", i - last_mid, 32);
            end
        end
        check_eq("os_tick_count", ticks, 32);
        check_eq("bit_tick_count", bits, 2);
        check_eq("mid_tick_count", mids, 2);

        // Restart in the cycle whose addition would carry.
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if ((m_total % M) + longint'(m_inc) >= M) begin n = 1; break; end
            step();
        end
        check_eq("carry_found", n, 1);
        restart = 1'b1; step(); restart = 1'b0;
        check_eq("restart_no_tick", os_tick, 0);
        steps_to_tick(200, n);
        check_eq("restart_next_tick", n, 4);
        check_eq("restart_phase", os_phase, 0);

        // Zero write is rejected.
        wr_inc(16'h0000);
        check_eq("zero_err", bus.inc_err, 1);
        check_eq("zero_ack", bus.inc_ack, 0);
        check_eq("zero_cur", bus.inc_cur, 16'h4000);
        step();
        check_eq("zero_err_pulse", bus.inc_err, 0);

        // Enable toggle: first tick after resume at ceil(2^16/inc).
        foreach (toggle_incs[k]) begin
            repeat (5) step();
            enable = 1'b0;
            step();
            check_eq("disable_no_tick", os_tick, 0);
            wr_inc(toggle_incs[k][15:0]);
            step();
            enable = 1'b1;
            steps_to_tick(200, n);
            check_eq("resume_first_tick", n,
                     (65536 + toggle_incs[k] - 1) / toggle_incs[k]);
            check_eq("resume_phase", os_phase, 0);
        end

        // Back-to-back writes while disabled: two acks, last value wins.
        enable = 1'b0;
        n = 0;
        bus.inc_wr = 1'b1; bus.inc_data = 16'h1000; step();
        if (bus.inc_ack) n++;
        bus.inc_data = 16'h4000; step();
        if (bus.inc_ack) n++;
        bus.inc_wr = 1'b0;
        step();
        if (bus.inc_ack) n++;
        check_eq("b2b_acks", n, 2);
        check_eq("b2b_cur", bus.inc_cur, 16'h4000);
        enable = 1'b1;

`ifdef BAUD_TICK_SHADOW_INC_EN
        // Shadow write mid-bit applies only at the bit boundary.
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (os_tick && os_phase == 4'd3) begin n = 1; break; end
        end
        check_eq("shadow_phase3_found", n, 1);
        wr_inc(16'h8000);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.inc_ack) begin n = 1; break; end
            check_eq("shadow_hold_cur", bus.inc_cur, 16'h4000);
            step();
        end
        check_eq("shadow_ack_seen", n, 1);
        check_eq("shadow_new_cur", bus.inc_cur, 16'h8000);
        steps_to_tick(50, n);
        steps_to_tick(50, n);
        check_eq("shadow_tick_gap", n, 2);
`endif

        // Reset mid-bit with a write outstanding.
        repeat (7) step();
        wr_inc(16'h2000);
        rst = 1'b1; step(); rst = 1'b0;
        check_eq("midbit_reset_cur", bus.inc_cur, INC_RESET);
        check_eq("midbit_reset_tick", os_tick, 0);
        repeat (3) step();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            enable       = ($urandom_range(0, 39) != 0);
            restart      = ($urandom_range(0, 59) == 0);
            bus.inc_wr   = ($urandom_range(0, 24) == 0);
            bus.inc_data = ($urandom_range(0, 3) == 0) ? 16'h0000
                                                       : 16'($urandom_range(1, 16'hFFFF));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen_prog.md
BAUD_TICK_GEN_PROG -- requirements
Module: baud_tick_gen_prog

Interface
REQ-001 Parameters SHALL be:
- CLK_FREQUENCY, 66000000, input clock frequency in Hz.
- BAUD, 9600, baud rate used to compute the reset increment.
- OVERSAMPLING, 16, oversample ticks per bit; legal values are 1 or an even number ≥2.
- ACC_WIDTH, 16, fractional accumulator width W.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run accumulator.
- restart  in  1  single-cycle phase realign.
- inc_wr  in  1  increment write strobe.
- inc_data  in  W  new increment.
- inc_ack  out  1  increment applied, one-cycle pulse.
- inc_err  out  1  write rejected, one-cycle pulse.
- inc_cur  out  W  increment in use.
- os_tick  out  1  oversample tick.
- mid_tick  out  1  mid-bit tick.
- bit_tick  out  1  bit-period tick.
- os_phase  out  max(1,clog2(OVERSAMPLING))  oversample index.

Function
REQ-003 INC_DEFAULT SHALL equal round-half-up(BAUD*OVERSAMPLING*2^W/CLK_FREQUENCY), computed at elaboration with ≥64-bit intermediates.
REQ-004 Elaboration SHALL fail if INC_DEFAULT is 0, if INC_DEFAULT ≥ 2^W, or if OVERSAMPLING is illegal.
REQ-005 The accumulator SHALL be W+1 bits; each cycle with enable=1, acc <= acc[W-1:0] + inc_cur, zero-extended.
REQ-006 os_tick SHALL equal registered acc[W]; it is high for exactly one cycle per carry.
REQ-007 With enable=0, acc SHALL be held at 0, os_phase SHALL be held at 0, and no ticks SHALL be produced.
REQ-008 restart=1 SHALL load acc=0 and os_phase=0 at the next edge, overriding a same-cycle carry; the first os_tick after restart therefore has os_phase=0.
REQ-009 os_phase SHALL report the index of the current os_tick (0..OVERSAMPLING-1) and increment after each os_tick, wrapping from OVERSAMPLING-1 to 0.
REQ-010 bit_tick SHALL be high in the os_tick cycle when os_phase=OVERSAMPLING-1.
REQ-011 mid_tick SHALL be high in the os_tick cycle when os_phase=OVERSAMPLING/2-1; when OVERSAMPLING=1, mid_tick=bit_tick=os_tick.
REQ-012 On inc_wr with inc_data≠0, inc_cur SHALL update at that edge, inc_ack SHALL pulse in the following cycle, and additions SHALL use the new value from that cycle onward.
REQ-013 On inc_wr with inc_data=0, inc_cur SHALL remain unchanged and inc_err SHALL pulse in the following cycle with no inc_ack.
REQ-014 Simultaneous inc_wr and restart SHALL perform both actions.
REQ-015 A back-to-back inc_wr SHALL apply each write in order, with one ack per write.

Reset
REQ-016 rst SHALL have priority over all inputs.
REQ-017 Reset SHALL set acc=0, os_phase=0, inc_cur=INC_DEFAULT, all tick/ack/err outputs to 0, and the pending flag (REQ-019) to 0.
REQ-018 Reset asserted mid-bit SHALL discard the pending shadow value and emit no tick in the cycle after reset.

Configuration
REQ-019 With macro BAUD_TICK_SHADOW_INC_EN defined:
- inc_wr writes a shadow register and sets a pending flag.
- The shadow value is copied to inc_cur in the bit_tick cycle, or at the next edge if enable=0.
- inc_ack pulses in the cycle after the copy.
- A write while pending overwrites the shadow; only one ack is produced.
- A zero write is rejected per REQ-013.
REQ-020 Without BAUD_TICK_SHADOW_INC_EN, behaviour SHALL be exactly REQ-012, and no shadow register SHALL exist.

Verification (W=16, OVERSAMPLING=16 unless stated)
REQ-021 Reset, then read inc_cur with CLK_FREQUENCY=66000000, BAUD=9600 -> inc_cur=153 and all ticks 0.
REQ-022 Write inc_data=0x4000 with enable=1 -> os_tick every 4 cycles, bit_tick every 64 cycles, mid_tick 32 cycles before each bit_tick, os_phase cycling 0..15.
REQ-023 Assert restart in a carry cycle at 0x4000 -> no os_tick in that cycle, next os_tick 4 cycles later with os_phase=0.
REQ-024 Write inc_data=0 -> inc_err one pulse, inc_ack 0, inc_cur unchanged.
REQ-025 With BAUD_TICK_SHADOW_INC_EN, at inc 0x4000 with os_phase=3, write 0x8000 -> inc_cur stays 0x4000 until bit_tick, then inc_ack pulses and os_tick occurs every 2 cycles.
REQ-026 Toggle enable 1->0->1 -> ticks stop immediately; on resume, first os_tick arrives ceil(2^16/inc) cycles later with os_phase=0.
